// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants, FSM states and command layout for the shift command sequencer
package shift_pkg;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int AMT_W_DEF  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } seq_state_t;

    // Queued command is packed as {sweep, dir, amount, data}
    function automatic int cmd_width(input int data_w, input int amt_w);
        return data_w + amt_w + 2;
    endfunction

    localparam int CMD_W_DEF = DATA_W_DEF + AMT_W_DEF + 2;

endpackage

// File: rtl/shift_cmd_seq_if.sv
// rtl/shift_cmd_seq_if.sv - producer handshake and shifter issue bundle for the shift command sequencer
interface shift_cmd_seq_if
    import shift_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_dir;
    logic [AMT_W-1:0]  cmd_amount;
    logic              cmd_sweep;

    logic [DATA_W-1:0] d_in;
    logic              shift_dir;
    logic [AMT_W-1:0]  shift_amount;
    logic              issue;
    logic              busy;
    logic [CNT_W-1:0]  count;

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_amount, cmd_sweep,
        input  cmd_ready, d_in, shift_dir, shift_amount, issue, busy, count
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_amount, cmd_sweep,
        output cmd_ready, d_in, shift_dir, shift_amount, issue, busy, count
    );

endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous FIFO with occupancy count, full/empty derived from the count
module cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Requests are qualified here so a full push or empty pop can never corrupt state
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; simultaneous push/pop keeps the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shift_cmd_seq.sv
// rtl/shift_cmd_seq.sv - queues shift commands and issues them to the barrel shifter, expanding sweeps
module shift_cmd_seq
    import shift_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_cmd_seq_if.slave       bus
);
    localparam int CMD_W     = cmd_width(DATA_W, AMT_W);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int DIR_BIT   = DATA_W + AMT_W;
    localparam int SWEEP_BIT = DATA_W + AMT_W + 1;

    logic [CMD_W-1:0]  w_wdata;
    logic [CMD_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head_data;
    logic [AMT_W-1:0]  w_head_amount;
    logic              w_head_dir;
    logic              w_head_sweep;

    seq_state_t        r_state;
    logic [AMT_W-1:0]  r_sweep_cnt;
    logic [DATA_W-1:0] r_d_in;
    logic              r_shift_dir;
    logic [AMT_W-1:0]  r_shift_amount;
    logic              r_issue;

    assign w_wdata = {bus.cmd_sweep, bus.cmd_dir, bus.cmd_amount, bus.cmd_data};
    assign w_push  = bus.cmd_valid && !w_full;
    // Only an idle sequencer consumes the head; the FIFO output is never bypassed from the input
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;

    assign w_head_data   = w_head[DATA_W-1:0];
    assign w_head_amount = w_head[DATA_W +: AMT_W];
    assign w_head_dir    = w_head[DIR_BIT];
    assign w_head_sweep  = w_head[SWEEP_BIT];

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Issue FSM: IDLE pops one command per cycle, SWEEP replays the held operand with amounts 1..max
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_sweep_cnt    <= '0;
            r_d_in         <= '0;
            r_shift_dir    <= SHIFT_RIGHT;
            r_shift_amount <= '0;
            r_issue        <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_d_in      <= w_head_data;
                        r_shift_dir <= w_head_dir;
                        r_issue     <= 1'b1;
                        if (w_head_sweep) begin
                            r_shift_amount <= '0;
                            r_sweep_cnt    <= AMT_W'(1);
                            r_state        <= ST_SWEEP;
                        end else begin
                            r_shift_amount <= w_head_amount;
                        end
                    end
                end
                ST_SWEEP: begin
                    r_shift_amount <= r_sweep_cnt;
                    r_issue        <= 1'b1;
                    r_sweep_cnt    <= r_sweep_cnt + AMT_W'(1);
                    if (r_sweep_cnt == {AMT_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = !w_full;
    assign bus.d_in         = r_d_in;
    assign bus.shift_dir    = r_shift_dir;
    assign bus.shift_amount = r_shift_amount;
    assign bus.issue        = r_issue;
    assign bus.busy         = (r_state == ST_SWEEP) || !w_empty;
    assign bus.count        = w_count;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb/tb_shift_cmd_seq.sv - directed self-checking bench for the shift command sequencer
module tb_shift_cmd_seq;
    import shift_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    shift_cmd_seq_if #(.DEPTH(4), .DATA_W(8), .AMT_W(3)) bus ();

    shift_cmd_seq #(.DEPTH(4), .DATA_W(8), .AMT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic dir, input logic [2:0] amt, input logic sw);
        bus.cmd_valid  = 1'b1;
        bus.cmd_data   = d;
        bus.cmd_dir    = dir;
        bus.cmd_amount = amt;
        bus.cmd_sweep  = sw;
    endtask

    task automatic idle_in();
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = 8'h00;
        bus.cmd_dir    = 1'b0;
        bus.cmd_amount = 3'd0;
        bus.cmd_sweep  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL reset_issue: got %b expected 0", bus.issue); end
        n_cmp++; if (bus.d_in !== 8'h00) begin n_err++; $display("FAIL reset_d_in: got %h expected 00", bus.d_in); end
        n_cmp++; if (bus.shift_dir !== 1'b0 || bus.shift_amount !== 3'd0) begin n_err++; $display("FAIL reset_dir_amt: got %b/%0d expected 0/0", bus.shift_dir, bus.shift_amount); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_busy_ready: got %b/%b expected 0/1", bus.busy, bus.cmd_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        drive(8'hA5, SHIFT_LEFT, 3'd3, 1'b0);
        tick();
        idle_in();
        n_cmp++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b expected 0", bus.issue); end
        n_cmp++; if (bus.count !== 3'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL single_queued: got count %0d busy %b expected 1/1", bus.count, bus.busy); end
        tick();
        n_cmp++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL single_issue: got %b expected 1", bus.issue); end
        n_cmp++; if ({bus.d_in, bus.shift_dir, bus.shift_amount} !== {8'hA5, 1'b1, 3'd3}) begin n_err++; $display("FAIL single_fields: got %h/%b/%0d expected a5/1/3", bus.d_in, bus.shift_dir, bus.shift_amount); end
        n_cmp++; if (bus.count !== 3'd0 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_drained: got count %0d ready %b expected 0/1", bus.count, bus.cmd_ready); end
        tick();
        n_cmp++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL single_one_shot: got %b expected 0", bus.issue); end
    endtask

    task automatic test_sweep();
        drive(8'h81, SHIFT_RIGHT, 3'd5, 1'b1);
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.issue !== 1'b1 || bus.shift_amount !== 3'(k) || bus.d_in !== 8'h81 || bus.shift_dir !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_step%0d: got issue %b amt %0d d %h dir %b expected 1/%0d/81/0", k, bus.issue, bus.shift_amount, bus.d_in, bus.shift_dir, k);
            end
        end
        tick();
        n_cmp++; if (bus.issue !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL sweep_end: got issue %b busy %b expected 0/0", bus.issue, bus.busy); end
    endtask

    task automatic test_full();
        logic [7:0] exp_d [5];
        logic       exp_dir [5];
        for (int i = 0; i < 5; i++) begin
            exp_d[i]   = 8'h10 + 8'(i * 8'h11);
            exp_dir[i] = i[0];
        end
        drive(8'h11, SHIFT_LEFT, 3'd0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(exp_d[i], exp_dir[i], 3'(i + 1), 1'b0);
            tick();
        end
        drive(exp_d[4], exp_dir[4], 3'd5, 1'b0);
        n_cmp++; if (bus.count !== 3'd4 || bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got count %0d ready %b expected 4/0", bus.count, bus.cmd_ready); end
        for (int k = 4; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.count !== 3'd4 || bus.shift_amount !== 3'(k) || bus.cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL full_hold%0d: got count %0d amt %0d ready %b expected 4/%0d/0", k, bus.count, bus.shift_amount, bus.cmd_ready, k);
            end
        end
        tick();
        n_cmp++; if (bus.count !== 3'd3 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_first_pop: got count %0d ready %b expected 3/1", bus.count, bus.cmd_ready); end
        n_cmp++; if (bus.issue !== 1'b1 || bus.d_in !== exp_d[0] || bus.shift_amount !== 3'd1) begin n_err++; $display("FAIL full_order0: got %b/%h/%0d expected 1/%h/1", bus.issue, bus.d_in, bus.shift_amount, exp_d[0]); end
        tick();
        idle_in();
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL full_fifth_accept: got count %0d expected 3", bus.count); end
        for (int i = 1; i < 5; i++) begin
            if (i > 1) tick();
            n_cmp++;
            if (bus.issue !== 1'b1 || bus.d_in !== exp_d[i] || bus.shift_dir !== exp_dir[i] || bus.shift_amount !== 3'(i + 1)) begin
                n_err++;
                $display("FAIL full_order%0d: got %b/%h/%b/%0d expected 1/%h/%b/%0d", i, bus.issue, bus.d_in, bus.shift_dir, bus.shift_amount, exp_d[i], exp_dir[i], i + 1);
            end
        end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL full_drain: got count %0d expected 0", bus.count); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hC1; exp_d[1] = 8'hC2; exp_d[2] = 8'hC3; exp_d[3] = 8'hC4;
        drive(8'h5A, SHIFT_RIGHT, 3'd0, 1'b1);
        tick();
        drive(exp_d[0], SHIFT_LEFT, 3'd6, 1'b0);
        tick();
        drive(exp_d[1], SHIFT_LEFT, 3'd6, 1'b0);
        tick();
        idle_in();
        for (int k = 2; k < 8; k++) tick();
        n_cmp++; if (bus.count !== 3'd2 || bus.shift_amount !== 3'd7) begin n_err++; $display("FAIL b2b_setup: got count %0d amt %0d expected 2/7", bus.count, bus.shift_amount); end
        drive(exp_d[2], SHIFT_LEFT, 3'd6, 1'b0);
        tick();
        n_cmp++; if (bus.count !== 3'd2 || bus.d_in !== exp_d[0] || bus.issue !== 1'b1) begin n_err++; $display("FAIL b2b_pushpop0: got count %0d d %h issue %b expected 2/%h/1", bus.count, bus.d_in, bus.issue, exp_d[0]); end
        drive(exp_d[3], SHIFT_LEFT, 3'd6, 1'b0);
        tick();
        idle_in();
        n_cmp++; if (bus.count !== 3'd2 || bus.d_in !== exp_d[1]) begin n_err++; $display("FAIL b2b_pushpop1: got count %0d d %h expected 2/%h", bus.count, bus.d_in, exp_d[1]); end
        for (int i = 2; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.issue !== 1'b1 || bus.d_in !== exp_d[i] || bus.count !== 3'(3 - i)) begin
                n_err++;
                $display("FAIL b2b_wrap%0d: got %b/%h/%0d expected 1/%h/%0d", i, bus.issue, bus.d_in, bus.count, exp_d[i], 3 - i);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        drive(8'hF0, SHIFT_LEFT, 3'd0, 1'b1);
        tick();
        drive(8'h77, SHIFT_LEFT, 3'd2, 1'b0);
        tick();
        idle_in();
        tick();
        tick();
        tick();
        n_cmp++; if (bus.shift_amount !== 3'd3 || bus.count !== 3'd1) begin n_err++; $display("FAIL rst_mid_setup: got amt %0d count %0d expected 3/1", bus.shift_amount, bus.count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.d_in !== 8'h00 || bus.shift_dir !== 1'b0 || bus.shift_amount !== 3'd0 || bus.issue !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got %h/%b/%0d/%b expected 00/0/0/0", bus.d_in, bus.shift_dir, bus.shift_amount, bus.issue); end
        n_cmp++; if (bus.count !== 3'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_fifo: got count %0d busy %b ready %b expected 0/0/1", bus.count, bus.busy, bus.cmd_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL rst_mid_quiet%0d: got issue %b expected 0", k, bus.issue); end
        end
    endtask

    task automatic test_empty_hold();
        drive(8'h3C, SHIFT_RIGHT, 3'd2, 1'b0);
        tick();
        idle_in();
        tick();
        n_cmp++; if (bus.issue !== 1'b1 || bus.d_in !== 8'h3C) begin n_err++; $display("FAIL hold_issue: got %b/%h expected 1/3c", bus.issue, bus.d_in); end
        tick();
        n_cmp++; if (bus.issue !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL hold_idle: got issue %b busy %b expected 0/0", bus.issue, bus.busy); end
        n_cmp++; if (bus.d_in !== 8'h3C || bus.shift_amount !== 3'd2 || bus.shift_dir !== 1'b0) begin n_err++; $display("FAIL hold_values: got %h/%0d/%b expected 3c/2/0", bus.d_in, bus.shift_amount, bus.shift_dir); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_in();
        test_reset();
        test_single();
        test_sweep();
        test_full();
        test_back_to_back();
        test_reset_mid_sweep();
        test_empty_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_cmd_seq.md
# shift_cmd_seq

Command sequencer directly upstream of the 8-bit barrel shifter. Buffers shift commands (data, direction, amount, sweep flag) from a valid/ready producer in a small FIFO. Issues them to the shifter's `d_in`/`shift_dir`/`shift_amount` inputs one per cycle. In sweep mode, one command expands into eight consecutive issues with amounts 0..7.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `DATA_W`, 8, operand width
- `AMT_W`, 3, shift-amount width; sweep length is 2**AMT_W

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `cmd_valid`  in  1  producer has a command
- `cmd_ready`  out  1  FIFO can accept; equals !full
- `cmd_data`  in  DATA_W  operand
- `cmd_dir`  in  1  0 = right, 1 = left
- `cmd_amount`  in  AMT_W  shift amount (ignored when sweep)
- `cmd_sweep`  in  1  1 = issue amounts 0..2**AMT_W-1
- `d_in`  out  DATA_W  operand to shifter, registered
- `shift_dir`  out  1  direction to shifter, registered
- `shift_amount`  out  AMT_W  amount to shifter, registered
- `issue`  out  1  outputs carry a new operation this cycle
- `busy`  out  1  FSM in SWEEP or FIFO non-empty
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {data, dir, amount, sweep} at the tail. `cmd_valid` while full is held off; nothing is dropped and nothing is overwritten.
- No bypass: a command is never issued in the cycle it is pushed.
- FSM states: IDLE, SWEEP.
- IDLE, FIFO non-empty, sweep=0:
  - Pop the head.
  - Register data/dir/amount to the outputs.
  - Assert `issue` for that cycle.
  - Stay in IDLE, so back-to-back commands issue every cycle.
- IDLE, FIFO non-empty, sweep=1:
  - Pop the head.
  - Register data/dir with amount 0 and assert `issue`.
  - Load the sweep counter with 1 and go to SWEEP.
- SWEEP:
  - Each cycle, drive amount = counter with the same data/dir and assert `issue`.
  - Counter increments modulo 2**AMT_W.
  - When the issued amount is 2**AMT_W-1, return to IDLE.
  - No pops occur during SWEEP.
- IDLE, FIFO empty: `issue` = 0. `d_in`/`shift_dir`/`shift_amount` hold their last values.
- Simultaneous push and pop: `count` is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty are derived from `count`.

## Timing
- Reset (rst=0, async): FSM to IDLE; FIFO cleared (`count` = 0); `d_in` = 0, `shift_dir` = 0, `shift_amount` = 0, `issue` = 0, `busy` = 0, `cmd_ready` = 1.
- Reset mid-sweep or with the FIFO occupied aborts all work immediately; queued commands are lost.
- Latency: a push at edge E into an empty, idle block gives `issue` = 1 in the cycle after edge E+1.
- The shifter captures the operation at the following edge.
- Sweep occupies exactly 2**AMT_W consecutive `issue` cycles; the next command issues in the cycle immediately after.
- `cmd_ready` is combinational from `count` only and never depends on `cmd_valid`.
- Throughput: 1 non-sweep command per cycle sustained.

## Structure
- Shared package `shift_pkg`:
  - `SHIFT_RIGHT` = 0, `SHIFT_LEFT` = 1
  - default DATA_W/AMT_W
  - FSM state constants
  - command field layout `{sweep, dir, amount, data}`, width DATA_W+AMT_W+2
- Sub-module `cmd_fifo`: synchronous FIFO parameterised by width and depth, with push/pop/full/empty/count.
- The FSM and output registers live in `shift_cmd_seq`.

## Test plan
- Reset, then a single push {0xA5, left, 3, sweep=0} at edge 1 → `issue` = 1 after edge 2 only; outputs 0xA5/1/3; `count` returns to 0; `cmd_ready` stays 1.
- Five pushes with `cmd_valid` held and issue blocked by a sweep in progress → `cmd_ready` drops at `count` = 4; the fifth command is accepted only after a pop; issue order equals push order.
- Sweep {0x81, right, x, sweep=1} → 8 consecutive `issue` cycles with amounts 0,1,...,7; data 0x81 and dir 0 constant; then IDLE.
- Push and pop in the same cycle at `count` = 2 → `count` stays 2; pointer wrap past DEPTH-1 preserves order.
- Reset asserted during sweep cycle 4 → outputs zero and `count` = 0 asynchronously; no `issue` after release until a new push.
- FIFO empty after an issue of 0x3C → `issue` = 0; `d_in` holds 0x3C; `busy` = 0.
